wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter DEPTH, default 2: long-latency result FIFO entries; legal values 2, 4 or 8.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 pipe_we  input  1  main-pipeline writeback request this cycle.
REQ-005 pipe_rd  input  5  destination register of the pipeline write.
REQ-006 pipe_wd  input  32  pipeline write data.
REQ-007 lu_valid  input  1  long-latency unit (divider/multi-cycle) result offered.
REQ-008 lu_ready  output  1  FIFO accepts a long-latency result this cycle.
REQ-009 lu_rd  input  5  long-latency destination register.
REQ-010 lu_wd  input  32  long-latency result data.
REQ-011 we3  output  1  register-file write enable.
REQ-012 a3  output  5  register-file write address.
REQ-013 wd3  output  32  register-file write data.
REQ-014 pending  output  32  bit n set = live queued result for register n; bit 0 always 0.
REQ-015 stall_req  output  1  FIFO full; hazard unit stalls the pipeline.

Function
REQ-016 The register-file write port outputs (we3, a3, wd3) shall be combinational from the current inputs and FIFO head; this is deliberate, so the register file's same-cycle write-through is not delayed.
REQ-017 A pipeline write is effective when pipe_we=1 and pipe_rd!=0; it shall always win the port: we3=1, a3=pipe_rd, wd3=pipe_wd.
REQ-018 With no effective pipeline write and a non-empty FIFO, the head shall be popped; we3 equals the head live bit, a3/wd3 equal the head rd/data.
REQ-019 With no effective pipeline write and an empty FIFO: we3=0, a3=0, wd3=0.
REQ-020 lu_ready shall be 1 exactly when FIFO occupancy < DEPTH (registered occupancy, no same-cycle pop credit).
REQ-021 Handshake: a result is accepted when lu_valid=1 and lu_ready=1; results with lu_rd=0 are accepted and discarded (no FIFO entry).
REQ-022 An accepted result is written to the register file no earlier than the following cycle (minimum latency 1).
REQ-023 Push and pop in the same cycle shall both take effect; occupancy is unchanged.
REQ-024 Write-after-write squash: an effective pipeline write to register r shall clear the live bit of every queued entry with rd=r; squashed entries still occupy a slot and are popped with we3=0.
REQ-025 A result accepted in the same cycle as an effective pipeline write to the same register shall be enqueued already squashed.
REQ-026 pending shall be the registered OR over live entries of one-hot(rd), updated the cycle after any push, pop or squash.
REQ-027 stall_req shall equal NOT lu_ready.
REQ-028 Read/write pointers shall wrap modulo DEPTH; occupancy shall be ceil(log2(DEPTH))+1 bits wide.

Reset
REQ-029 While reset=1 the FIFO shall be empty: occupancy 0, pointers 0, all live bits 0.
REQ-030 After reset, outputs settle to: lu_ready=1, pending=0, stall_req=0; we3/a3/wd3 follow the pipeline inputs only.
REQ-031 A reset asserted mid-operation shall discard all queued results with no register-file write; lu_valid is ignored in that cycle.

Structure
REQ-032 The FIFO entry type (live bit, 5-bit rd, 32-bit data) and the DEPTH legality check shall be declared in the shared core package.
REQ-033 The queue shall be one sub-module, wb_fifo, with squash-by-address port; the port arbitration and pending mask stay in wb_arbiter.

Verification
REQ-034 Result lu x5=0x0000_00AA accepted, pipe_we=0 -> next cycle we3=1, a3=5, wd3=0xAA; pending[5] 1 then 0.
REQ-035 Result x7=0x11 queued while pipe writes x3 for 3 cycles -> x7 held, pending[7]=1; first idle cycle writes x7.
REQ-036 Result x9 queued, then pipe writes x9=0x22 -> x9 entry squashed, later popped with we3=0, pending[9] cleared.
REQ-037 DEPTH=2, two results queued under continuous pipe writes -> lu_ready=0, stall_req=1; third lu_valid is held, not accepted.
REQ-038 Result x0 offered -> accepted, no entry, we3 never asserted for it, pending=0.
REQ-039 Two results queued, reset pulsed one cycle -> no register-file write afterwards, pending=0, lu_ready=1.

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
// Shared types and helpers for the writeback arbiter: the queued-result entry
// and the legality check on the result FIFO depth.
package wb_arbiter_pkg;

  localparam int REG_W  = 5;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic              live;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  function automatic bit depth_is_legal(input int depth);
    return (depth == 2) || (depth == 4) || (depth == 8);
  endfunction

  function automatic logic [31:0] reg_onehot(input logic [REG_W-1:0] rd);
    return 32'd1 << rd;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Long-latency result queue: power-of-two ring buffer whose entries can be
// squashed by destination register while they wait.
module wb_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              push_i,
  input  wb_entry_t         push_entry_i,
  input  logic              pop_i,
  input  logic              squash_en_i,
  input  logic [REG_W-1:0]  squash_rd_i,
  output wb_entry_t         head_o,
  output logic              empty_o,
  output logic [$clog2(DEPTH):0] count_d_o,
  output logic [31:0]       live_mask_d_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_entry_t         entries_q [DEPTH];
  wb_entry_t         entries_d [DEPTH];
  logic [PW-1:0]     wr_q, wr_d;
  logic [PW-1:0]     rd_q, rd_d;
  logic [CW-1:0]     count_q, count_d;
  logic [31:0]       live_mask_d;

  // State registers with synchronous clear of every slot.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= '0;
      end
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      entries_q <= entries_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      count_q   <= count_d;
    end
  end

  // Next state: squash first, so a pushed entry keeps the live bit it arrives with.
  always_comb begin
    entries_d   = entries_q;
    live_mask_d = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      entries_d[i].live = entries_q[i].live &&
                          !(squash_en_i && (entries_q[i].rd == squash_rd_i));
    end
    if (pop_i) begin
      entries_d[rd_q].live = 1'b0;
      rd_d = rd_q + PW'(1);
    end else begin
      rd_d = rd_q;
    end
    if (push_i) begin
      entries_d[wr_q] = push_entry_i;
      wr_d = wr_q + PW'(1);
    end else begin
      wr_d = wr_q;
    end
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    for (int i = 0; i < DEPTH; i++) begin
      live_mask_d = live_mask_d |
                    (entries_d[i].live ? reg_onehot(entries_d[i].rd) : 32'd0);
    end
    live_mask_d[0] = 1'b0;
  end

  assign head_o        = entries_q[rd_q];
  assign empty_o       = (count_q == CW'(0));
  assign count_d_o     = count_d;
  assign live_mask_d_o = live_mask_d;

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: pipeline writes always win; long-latency
// results wait in wb_fifo and drain on idle cycles, with WAW squashing.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pipe_we,
  input  logic [REG_W-1:0]  pipe_rd,
  input  logic [DATA_W-1:0] pipe_wd,
  input  logic              lu_valid,
  output logic              lu_ready,
  input  logic [REG_W-1:0]  lu_rd,
  input  logic [DATA_W-1:0] lu_wd,
  output logic              we3,
  output logic [REG_W-1:0]  a3,
  output logic [DATA_W-1:0] wd3,
  output logic [31:0]       pending,
  output logic              stall_req
);

  localparam int CW = $clog2(DEPTH) + 1;

  if (!depth_is_legal(DEPTH)) begin : g_bad_depth
    $error("wb_arbiter: DEPTH must be 2, 4 or 8");
  end

  logic          eff_pipe_s;
  logic          push_s;
  logic          pop_s;
  wb_entry_t     push_entry_s;
  wb_entry_t     head_s;
  logic          empty_s;
  logic [CW-1:0] count_d_s;
  logic [31:0]   mask_d_s;
  logic          lu_ready_q;
  logic          stall_q;
  logic [31:0]   pending_q;

  assign eff_pipe_s = pipe_we && (pipe_rd != 5'd0);
  // Reset gates both ends of the queue so nothing leaks into the register file.
  assign push_s     = lu_valid && lu_ready_q && !reset && (lu_rd != 5'd0);
  assign pop_s      = !eff_pipe_s && !empty_s && !reset;

  // Entry offered this cycle, born squashed if the pipeline writes the same register now.
  always_comb begin
    push_entry_s.live = !(eff_pipe_s && (pipe_rd == lu_rd));
    push_entry_s.rd   = lu_rd;
    push_entry_s.data = lu_wd;
  end

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i         (clk),
    .reset_i       (reset),
    .push_i        (push_s),
    .push_entry_i  (push_entry_s),
    .pop_i         (pop_s),
    .squash_en_i   (eff_pipe_s),
    .squash_rd_i   (pipe_rd),
    .head_o        (head_s),
    .empty_o       (empty_s),
    .count_d_o     (count_d_s),
    .live_mask_d_o (mask_d_s)
  );

  // Write-port mux, combinational so register-file write-through is not delayed.
  always_comb begin
    if (eff_pipe_s) begin
      we3 = 1'b1;
      a3  = pipe_rd;
      wd3 = pipe_wd;
    end else if (pop_s) begin
      we3 = head_s.live;
      a3  = head_s.rd;
      wd3 = head_s.data;
    end else begin
      we3 = 1'b0;
      a3  = 5'd0;
      wd3 = 32'd0;
    end
  end

  // Flow-control and pending-mask registers, derived from next FIFO state.
  always_ff @(posedge clk) begin
    if (reset) begin
      lu_ready_q <= 1'b1;
      stall_q    <= 1'b0;
      pending_q  <= 32'd0;
    end else begin
      lu_ready_q <= (count_d_s < CW'(DEPTH));
      stall_q    <= !(count_d_s < CW'(DEPTH));
      pending_q  <= mask_d_s;
    end
  end

  assign lu_ready  = lu_ready_q;
  assign stall_req = stall_q;
  assign pending   = pending_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter at DEPTH=2.
module tb_wb_arbiter;

  logic        clk;
  logic        reset;
  logic        pipe_we;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_wd;
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_rd;
  logic [31:0] lu_wd;
  logic        we3;
  logic [4:0]  a3;
  logic [31:0] wd3;
  logic [31:0] pending;
  logic        stall_req;

  int total = 0;
  int bad   = 0;

  wb_arbiter #(.DEPTH(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .pipe_we   (pipe_we),
    .pipe_rd   (pipe_rd),
    .pipe_wd   (pipe_wd),
    .lu_valid  (lu_valid),
    .lu_ready  (lu_ready),
    .lu_rd     (lu_rd),
    .lu_wd     (lu_wd),
    .we3       (we3),
    .a3        (a3),
    .wd3       (wd3),
    .pending   (pending),
    .stall_req (stall_req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are then changed away from it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic pipe(input logic we, input logic [4:0] rd, input logic [31:0] wd);
    pipe_we = we;
    pipe_rd = rd;
    pipe_wd = wd;
  endtask

  task automatic lu(input logic v, input logic [4:0] rd, input logic [31:0] wd);
    lu_valid = v;
    lu_rd    = rd;
    lu_wd    = wd;
  endtask

  task automatic port(input string tag, input logic w, input logic [4:0] a, input logic [31:0] d);
    chk({tag, ".we3"}, 32'(we3), 32'(w));
    chk({tag, ".a3"},  32'(a3),  32'(a));
    chk({tag, ".wd3"}, wd3, d);
  endtask

  initial begin
    reset = 1'b1;
    pipe(1'b0, 5'd0, 32'd0);
    lu(1'b0, 5'd0, 32'd0);
    cyc();
    cyc();
    reset = 1'b0;
    settle();
    chk("rst.lu_ready", 32'(lu_ready), 32'd1);
    chk("rst.stall", 32'(stall_req), 32'd0);
    chk("rst.pending", pending, 32'd0);
    port("rst", 1'b0, 5'd0, 32'd0);

    // Single result drains on the next idle cycle
    lu(1'b1, 5'd5, 32'h0000_00AA);
    settle();
    port("x5.accept", 1'b0, 5'd0, 32'd0);
    cyc();
    lu(1'b0, 5'd0, 32'd0);
    settle();
    port("x5.write", 1'b1, 5'd5, 32'h0000_00AA);
    chk("x5.pending1", pending, 32'h0000_0020);
    cyc();
    settle();
    port("x5.after", 1'b0, 5'd0, 32'd0);
    chk("x5.pending0", pending, 32'd0);

    // Result held behind three pipeline writes
    pipe(1'b1, 5'd3, 32'h33);
    lu(1'b1, 5'd7, 32'h11);
    settle();
    port("x7.p1", 1'b1, 5'd3, 32'h33);
    cyc();
    lu(1'b0, 5'd0, 32'd0);
    settle();
    port("x7.p2", 1'b1, 5'd3, 32'h33);
    chk("x7.pend2", pending, 32'h0000_0080);
    cyc();
    settle();
    chk("x7.pend3", pending, 32'h0000_0080);
    cyc();
    pipe(1'b0, 5'd0, 32'd0);
    settle();
    port("x7.drain", 1'b1, 5'd7, 32'h11);
    cyc();
    settle();
    chk("x7.pend0", pending, 32'd0);
    port("x7.idle", 1'b0, 5'd0, 32'd0);

    // Queued x9 squashed by a later pipeline write to x9
    pipe(1'b1, 5'd3, 32'h33);
    lu(1'b1, 5'd9, 32'h99);
    cyc();
    lu(1'b0, 5'd0, 32'd0);
    pipe(1'b1, 5'd9, 32'h22);
    settle();
    port("x9.pipe", 1'b1, 5'd9, 32'h22);
    chk("x9.pend1", pending, 32'h0000_0200);
    cyc();
    pipe(1'b0, 5'd0, 32'd0);
    settle();
    chk("x9.pend0", pending, 32'd0);
    port("x9.pop_dead", 1'b0, 5'd9, 32'h99);
    cyc();
    settle();
    port("x9.empty", 1'b0, 5'd0, 32'd0);

    // Accepted in the same cycle as a pipeline write to the same register
    pipe(1'b1, 5'd4, 32'h45);
    lu(1'b1, 5'd4, 32'h44);
    cyc();
    pipe(1'b0, 5'd0, 32'd0);
    lu(1'b0, 5'd0, 32'd0);
    settle();
    chk("x4.pend", pending, 32'd0);
    port("x4.pop_dead", 1'b0, 5'd4, 32'h44);
    cyc();

    // Fill DEPTH=2 under continuous pipe writes; third offer is held
    pipe(1'b1, 5'd3, 32'h33);
    lu(1'b1, 5'd10, 32'hA0);
    settle();
    chk("full.rdyA", 32'(lu_ready), 32'd1);
    cyc();
    lu(1'b1, 5'd11, 32'hB0);
    settle();
    chk("full.rdyB", 32'(lu_ready), 32'd1);
    chk("full.pendB", pending, 32'h0000_0400);
    cyc();
    lu(1'b1, 5'd12, 32'hC0);
    settle();
    chk("full.rdyC", 32'(lu_ready), 32'd0);
    chk("full.stallC", 32'(stall_req), 32'd1);
    chk("full.pendC", pending, 32'h0000_0C00);
    cyc();
    settle();
    chk("full.rdyD", 32'(lu_ready), 32'd0);
    cyc();
    pipe(1'b0, 5'd0, 32'd0);
    settle();
    port("full.popE", 1'b1, 5'd10, 32'hA0);
    chk("full.rdyE", 32'(lu_ready), 32'd0);
    cyc();
    settle();
    chk("full.rdyF", 32'(lu_ready), 32'd1);
    chk("full.stallF", 32'(stall_req), 32'd0);
    port("full.popF", 1'b1, 5'd11, 32'hB0);
    chk("full.pendF", pending, 32'h0000_0800);
    cyc();
    lu(1'b0, 5'd0, 32'd0);
    settle();
    port("full.popG", 1'b1, 5'd12, 32'hC0);
    chk("full.pendG", pending, 32'h0000_1000);
    cyc();
    settle();
    port("full.empty", 1'b0, 5'd0, 32'd0);
    chk("full.pend0", pending, 32'd0);

    // x0 results and x0 pipeline writes are never written
    lu(1'b1, 5'd0, 32'hDEAD);
    settle();
    port("x0.offer", 1'b0, 5'd0, 32'd0);
    cyc();
    lu(1'b0, 5'd0, 32'd0);
    pipe(1'b1, 5'd0, 32'hBEEF);
    settle();
    port("x0.after", 1'b0, 5'd0, 32'd0);
    chk("x0.pend", pending, 32'd0);
    chk("x0.rdy", 32'(lu_ready), 32'd1);
    cyc();

    // Reset pulse discards two queued results
    pipe(1'b1, 5'd3, 32'h33);
    lu(1'b1, 5'd13, 32'hD0);
    cyc();
    lu(1'b1, 5'd14, 32'hE0);
    cyc();
    pipe(1'b0, 5'd0, 32'd0);
    lu(1'b1, 5'd15, 32'hF0);
    reset = 1'b1;
    settle();
    chk("rstmid.pend_before", pending, 32'h0000_6000);
    port("rstmid.during", 1'b0, 5'd0, 32'd0);
    cyc();
    reset = 1'b0;
    lu(1'b0, 5'd0, 32'd0);
    settle();
    chk("rstmid.pend", pending, 32'd0);
    chk("rstmid.rdy", 32'(lu_ready), 32'd1);
    chk("rstmid.stall", 32'(stall_req), 32'd0);
    port("rstmid.after", 1'b0, 5'd0, 32'd0);
    cyc();
    settle();
    port("rstmid.after2", 1'b0, 5'd0, 32'd0);
    chk("rstmid.pend2", pending, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
